// File: rtl/mem_io_bridge.sv
// Data-memory responder for the CPU core: word-addressed data RAM plus a small
// memory-mapped I/O page (7-seg, timer, LEDs, switches, buttons) at 0xFFFF_F000.
module mem_io_bridge #(
  parameter int DRAM_AW  = 14,
  parameter int LED_W    = 24,
  parameter int SW_W     = 24,
  parameter int TICK_DIV = 100000,
  parameter int SCAN_DIV = 50000,
  parameter int DEB_DIV  = 200000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              dram_we,
  input  logic [31:0]       addr,
  input  logic [31:0]       write_data,
  output logic [31:0]       read_data,
  input  logic [SW_W-1:0]   sw_i,
  input  logic [4:0]        btn_i,
  output logic [LED_W-1:0]  led_o,
  output logic [7:0]        seg_en_o,
  output logic [7:0]        seg_o,
  output logic              bus_err_o
);

  localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int SW_CW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int DW = (DEB_DIV > 1) ? $clog2(DEB_DIV) : 1;

  localparam logic [TW-1:0]    TICK_LAST = TW'(TICK_DIV - 1);
  localparam logic [SW_CW-1:0] SCAN_LAST = SW_CW'(SCAN_DIV - 1);
  localparam logic [DW-1:0]    DEB_LAST  = DW'(DEB_DIV - 1);

  // word offsets (addr[11:2]) inside the I/O page
  localparam logic [9:0] W_SEG   = 10'h000;
  localparam logic [9:0] W_TIMER = 10'h008;
  localparam logic [9:0] W_LED   = 10'h018;
  localparam logic [9:0] W_SW    = 10'h01C;
  localparam logic [9:0] W_BTN   = 10'h01E;

  logic [31:0]        mem [0:(1<<DRAM_AW)-1];
  logic [DRAM_AW-1:0] dram_idx;
  logic               io_sel;
  logic [9:0]         io_word;
  logic               io_mapped;

  logic [31:0]        seg_reg;
  logic [31:0]        timer;
  logic [TW-1:0]      presc;
  logic [SW_CW-1:0]   scan_cnt;
  logic [2:0]         scan_idx;
  logic [3:0]         seg_nib;
  logic [6:0]         seg_dec;

  logic [SW_W-1:0]    sw_s1;
  logic [SW_W-1:0]    sw_s2;
  logic [4:0]         btn_s1;
  logic [4:0]         btn_s2;
  logic [4:0]         btn_smp;
  logic [4:0]         btn_deb;
  logic [4:0]         btn_agree;
  logic [DW-1:0]      deb_cnt;

  logic               unused;

  assign unused    = ^addr[1:0];
  assign io_sel    = (addr[31:12] == 20'hFFFFF);
  assign io_word   = addr[11:2];
  assign dram_idx  = addr[DRAM_AW+1:2];
  assign io_mapped = (io_word == W_SEG) || (io_word == W_TIMER) || (io_word == W_LED) ||
                     (io_word == W_SW)  || (io_word == W_BTN);

  always_comb begin
    read_data = '0;
    if (!io_sel) begin
      read_data = mem[dram_idx];
    end else begin
      case (io_word)
        W_SEG:   read_data = seg_reg;
        W_TIMER: read_data = timer;
        W_LED:   read_data = 32'(led_o);
        W_SW:    read_data = 32'(sw_s2);
        W_BTN:   read_data = 32'(btn_deb);
        default: read_data = '0;
      endcase
    end
  end

  // RAM has no reset; a strobe coinciding with rst is dropped like every other write
  always_ff @(posedge clk) begin
    if (dram_we && !io_sel && !rst) begin
      mem[dram_idx] <= write_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      seg_reg   <= '0;
      led_o     <= '0;
      bus_err_o <= 1'b0;
    end else begin
      if (dram_we && io_sel && io_word == W_SEG) begin
        seg_reg <= write_data;
      end
      if (dram_we && io_sel && io_word == W_LED) begin
        led_o <= write_data[LED_W-1:0];
      end
      // any access to an unmapped I/O word, read or write, latches the error
      if (io_sel && !io_mapped) begin
        bus_err_o <= 1'b1;
      end
    end
  end

  // a CPU load of TIMER takes priority over the tick landing in the same cycle
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      timer <= '0;
      presc <= '0;
    end else if (dram_we && io_sel && io_word == W_TIMER) begin
      timer <= write_data;
      presc <= '0;
    end else if (presc == TICK_LAST) begin
      timer <= timer + 32'd1;
      presc <= '0;
    end else begin
      presc <= presc + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      scan_cnt <= SCAN_LAST;
      scan_idx <= '0;
    end else if (scan_cnt == '0) begin
      scan_cnt <= SCAN_LAST;
      scan_idx <= scan_idx + 3'd1;
    end else begin
      scan_cnt <= scan_cnt - 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sw_s1  <= '0;
      sw_s2  <= '0;
      btn_s1 <= '0;
      btn_s2 <= '0;
    end else begin
      sw_s1  <= sw_i;
      sw_s2  <= sw_s1;
      btn_s1 <= btn_i;
      btn_s2 <= btn_s1;
    end
  end

  // a debounced bit only moves once two consecutive samples agree on it
  assign btn_agree = ~(btn_s2 ^ btn_smp);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      deb_cnt <= DEB_LAST;
      btn_smp <= '0;
      btn_deb <= '0;
    end else if (deb_cnt == '0) begin
      deb_cnt <= DEB_LAST;
      btn_smp <= btn_s2;
      btn_deb <= (btn_agree & btn_s2) | (~btn_agree & btn_deb);
    end else begin
      deb_cnt <= deb_cnt - 1'b1;
    end
  end

  assign seg_nib = seg_reg[{scan_idx, 2'b00} +: 4];

  always_comb begin
    seg_dec = 7'h7F;
    case (seg_nib)
      4'h0: seg_dec = 7'h40;
      4'h1: seg_dec = 7'h79;
      4'h2: seg_dec = 7'h24;
      4'h3: seg_dec = 7'h30;
      4'h4: seg_dec = 7'h19;
      4'h5: seg_dec = 7'h12;
      4'h6: seg_dec = 7'h02;
      4'h7: seg_dec = 7'h78;
      4'h8: seg_dec = 7'h00;
      4'h9: seg_dec = 7'h10;
      4'hA: seg_dec = 7'h08;
      4'hB: seg_dec = 7'h03;
      4'hC: seg_dec = 7'h46;
      4'hD: seg_dec = 7'h21;
      4'hE: seg_dec = 7'h06;
      4'hF: seg_dec = 7'h0E;
      default: seg_dec = 7'h7F;
    endcase
  end

  assign seg_o    = {1'b1, seg_dec};
  assign seg_en_o = ~(8'd1 << scan_idx);

endmodule

// File: tb/tb_mem_io_bridge.sv
// Scoreboard bench for mem_io_bridge: expectations are queued as stimulus is
// applied and popped when the corresponding DUT output is sampled.
module tb_mem_io_bridge;

  localparam int DRAM_AW  = 14;
  localparam int LED_W    = 24;
  localparam int SW_W     = 24;
  localparam int TICK_DIV = 10;
  localparam int SCAN_DIV = 4;
  localparam int DEB_DIV  = 4;

  localparam logic [31:0] A_SEG   = 32'hFFFF_F000;
  localparam logic [31:0] A_TIMER = 32'hFFFF_F020;
  localparam logic [31:0] A_LED   = 32'hFFFF_F060;
  localparam logic [31:0] A_SW    = 32'hFFFF_F070;
  localparam logic [31:0] A_BTN   = 32'hFFFF_F078;
  localparam logic [31:0] A_BAD   = 32'hFFFF_F100;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              dram_we = 1'b0;
  logic [31:0]       addr = '0;
  logic [31:0]       write_data = '0;
  logic [31:0]       read_data;
  logic [SW_W-1:0]   sw_i = '0;
  logic [4:0]        btn_i = '0;
  logic [LED_W-1:0]  led_o;
  logic [7:0]        seg_en_o;
  logic [7:0]        seg_o;
  logic              bus_err_o;

  typedef struct {
    string       tag;
    logic [31:0] val;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_err = 0;

  mem_io_bridge #(
    .DRAM_AW(DRAM_AW), .LED_W(LED_W), .SW_W(SW_W),
    .TICK_DIV(TICK_DIV), .SCAN_DIV(SCAN_DIV), .DEB_DIV(DEB_DIV)
  ) dut (
    .clk(clk), .rst(rst), .dram_we(dram_we), .addr(addr),
    .write_data(write_data), .read_data(read_data), .sw_i(sw_i),
    .btn_i(btn_i), .led_o(led_o), .seg_en_o(seg_en_o), .seg_o(seg_o),
    .bus_err_o(bus_err_o)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s got=%h want=%h", tag, obs, exp);
    end
  endtask

  task automatic sb_push(input string tag, input logic [31:0] v);
    exp_t e;
    e.tag = tag;
    e.val = v;
    exp_q.push_back(e);
  endtask

  task automatic pop_cmp(input logic [31:0] obs);
    exp_t e;
    if (exp_q.size() == 0) begin
      n_cmp++;
      n_err++;
      $display("FAIL sb_empty got=%h want=<queued value>", obs);
    end else begin
      e = exp_q.pop_front();
      check_val(e.tag, obs, e.val);
    end
  endtask

  task automatic rd(input string tag, input logic [31:0] a, input logic [31:0] v);
    sb_push(tag, v);
    addr = a;
    #1;
    pop_cmp(read_data);
  endtask

  // strobe is committed at the next rising edge; returns at the following falling edge
  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    addr       = a;
    write_data = d;
    dram_we    = 1'b1;
    @(negedge clk);
    dram_we    = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    do_reset();

    // reset state
    addr = A_TIMER;
    sb_push("rst_led", 32'h0);
    sb_push("rst_seg_en", 32'hFE);
    sb_push("rst_seg", 32'hC0);
    sb_push("rst_bus_err", 32'h0);
    #1;
    pop_cmp(32'(led_o));
    pop_cmp(32'(seg_en_o));
    pop_cmp(32'(seg_o));
    pop_cmp(32'(bus_err_o));
    rd("rst_timer", A_TIMER, 32'h0);

    // two prescaler wraps by edge 25
    repeat (25) @(negedge clk);
    rd("timer_25", A_TIMER, 32'd2);

    wr(A_TIMER, 32'hFFFF_FFFF);
    repeat (9) @(negedge clk);
    rd("timer_pre_wrap", A_TIMER, 32'hFFFF_FFFF);
    @(negedge clk);
    rd("timer_wrap", A_TIMER, 32'h0);

    // load lands on the 10th edge after reset, where the tick would fire
    do_reset();
    repeat (9) @(negedge clk);
    wr(A_TIMER, 32'h55);
    rd("timer_load_vs_tick", A_TIMER, 32'h55);
    repeat (9) @(negedge clk);
    rd("timer_presc_cleared", A_TIMER, 32'h55);
    @(negedge clk);
    rd("timer_after_load", A_TIMER, 32'h56);

    // data RAM
    wr(32'h0000_0010, 32'hDEAD_BEEF);
    rd("dram_rd", 32'h0000_0010, 32'hDEAD_BEEF);
    rd("dram_alias", 32'h0001_0010, 32'hDEAD_BEEF);
    @(negedge clk);
    addr       = 32'h0000_0010;
    write_data = 32'h1;
    dram_we    = 1'b1;
    sb_push("dram_same_cycle", 32'hDEAD_BEEF);
    #1;
    pop_cmp(read_data);
    @(negedge clk);
    dram_we = 1'b0;
    rd("dram_new", 32'h0000_0010, 32'h1);
    wr(32'hFFFF_EFFC, 32'hCAFE_0001);
    rd("dram_top_alias", 32'h0000_EFFC, 32'hCAFE_0001);
    sb_push("dram_no_err", 32'h0);
    pop_cmp(32'(bus_err_o));

    // LED
    @(negedge clk);
    wr(A_LED, 32'hFFFF_FFFF);
    sb_push("led_out", 32'h00FF_FFFF);
    pop_cmp(32'(led_o));
    rd("led_rd", A_LED, 32'h00FF_FFFF);

    // 7-seg scan, phase aligned to reset
    do_reset();
    wr(A_SEG, 32'h1234_5678);
    rd("seg_rd", A_SEG, 32'h1234_5678);
    sb_push("seg_d0", 32'h80);
    sb_push("seg_en_d0", 32'hFE);
    pop_cmp(32'(seg_o));
    pop_cmp(32'(seg_en_o));
    repeat (4) @(negedge clk);
    sb_push("seg_d1", 32'hF8);
    sb_push("seg_en_d1", 32'hFD);
    #1;
    pop_cmp(32'(seg_o));
    pop_cmp(32'(seg_en_o));
    repeat (24) @(negedge clk);
    sb_push("seg_d7", 32'hF9);
    sb_push("seg_en_d7", 32'h7F);
    #1;
    pop_cmp(32'(seg_o));
    pop_cmp(32'(seg_en_o));
    repeat (4) @(negedge clk);
    sb_push("seg_wrap", 32'h80);
    sb_push("seg_en_wrap", 32'hFE);
    #1;
    pop_cmp(32'(seg_o));
    pop_cmp(32'(seg_en_o));

    // switch synchroniser
    @(negedge clk);
    sw_i = 24'h00A5A5;
    addr = A_SW;
    @(negedge clk);
    rd("sw_1edge", A_SW, 32'h0);
    @(negedge clk);
    rd("sw_2edge", A_SW, 32'h0000_A5A5);
    wr(A_SW, 32'hFFFF_FFFF);
    rd("sw_ro", A_SW, 32'h0000_A5A5);
    sb_push("sw_wr_no_err", 32'h0);
    pop_cmp(32'(bus_err_o));

    // button debounce
    @(negedge clk);
    btn_i = 5'b00100;
    repeat (3) @(negedge clk);
    btn_i = 5'b00000;
    repeat (12) @(negedge clk);
    rd("btn_glitch", A_BTN, 32'h0);
    btn_i = 5'b00100;
    repeat (12) @(negedge clk);
    rd("btn_held", A_BTN, 32'h04);
    btn_i = 5'b00000;

    // unmapped access, then reset mid-operation
    do_reset();
    wr(A_TIMER, 32'd7);
    wr(A_LED, 32'hFF);
    rd("unmapped_rd", A_BAD, 32'h0);
    sb_push("bus_err_before", 32'h0);
    pop_cmp(32'(bus_err_o));
    @(negedge clk);
    addr = A_TIMER;
    sb_push("bus_err_set", 32'h1);
    #1;
    pop_cmp(32'(bus_err_o));
    rd("timer_7", A_TIMER, 32'd7);
    sb_push("led_ff", 32'hFF);
    pop_cmp(32'(led_o));
    repeat (3) @(negedge clk);
    sb_push("bus_err_sticky", 32'h1);
    #1;
    pop_cmp(32'(bus_err_o));
    #1;
    rst = 1'b1;
    sb_push("async_rst_led", 32'h0);
    sb_push("async_rst_bus_err", 32'h0);
    sb_push("async_rst_seg", 32'hC0);
    #1;
    pop_cmp(32'(led_o));
    pop_cmp(32'(bus_err_o));
    pop_cmp(32'(seg_o));
    rd("async_rst_timer", A_TIMER, 32'h0);
    @(negedge clk);
    rst = 1'b0;

    check_val("sb_drain", 32'(exp_q.size()), 32'h0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
